// File: rtl/pipe_adder.sv
// Segmented pipelined adder/subtractor: one SEG-bit slice per stage, ready/valid flow control.
// Optional signed-overflow output enabled by defining PIPE_ADDER_OVF_EN.
module pipe_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = (SEG >= 1) ? WIDTH / SEG : 1;
  localparam int REM    = (SEG >= 1) ? WIDTH % SEG : 1;

  if (SEG < 1 || WIDTH < SEG || REM != 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a nonzero multiple of SEG, SEG >= 1");
  end

  logic advance;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operands shrink by one segment per stage; the low slice is the one summed here.
    localparam int WI = WIDTH - k * SEG;

    logic [WI-1:0]         a_i;
    logic [WI-1:0]         b_i;
    logic                  c_i;
    logic                  v_i;
    logic                  vld_q;
    logic [SEG:0]          seg;
    logic [(k+1)*SEG-1:0]  s_nx;

    if (k == 0) begin : g_in
      assign a_i  = a;
      assign b_i  = sub ? ~b : b;
      assign c_i  = sub;
      assign v_i  = in_valid;
      assign s_nx = seg[SEG-1:0];
    end else begin : g_in
      assign a_i  = g_stage[k-1].g_fwd.a_q;
      assign b_i  = g_stage[k-1].g_fwd.b_q;
      assign c_i  = g_stage[k-1].g_fwd.c_q;
      assign v_i  = g_stage[k-1].vld_q;
      assign s_nx = {seg[SEG-1:0], g_stage[k-1].g_fwd.s_q};
    end

    assign seg = {1'b0, a_i[SEG-1:0]} + {1'b0, b_i[SEG-1:0]} + {{SEG{1'b0}}, c_i};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
      end else if (advance) begin
        vld_q <= v_i;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      // ---- stage k -> stage k+1 boundary ----
      logic [WI-SEG-1:0]    a_q;
      logic [WI-SEG-1:0]    b_q;
      logic [(k+1)*SEG-1:0] s_q;
      logic                 c_q;

      always_ff @(posedge clk) begin
        if (advance) begin
          a_q <= a_i[WI-1:SEG];
          b_q <= b_i[WI-1:SEG];
          s_q <= s_nx;
          c_q <= seg[SEG];
        end
      end
    end else begin : g_out
      // ---- final stage -> output boundary ----
      assign out_valid = vld_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out <= '0;
        end else if (advance) begin
          out <= {seg[SEG], s_nx};
        end
      end

`ifdef PIPE_ADDER_OVF_EN
      // Carry into the MSB is a^b^s at that bit; overflow when it differs from carry-out.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf <= 1'b0;
        end else if (advance) begin
          ovf <= a_i[SEG-1] ^ b_i[SEG-1] ^ seg[SEG-1] ^ seg[SEG];
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder (WIDTH=16, SEG=4) with a queue scoreboard for results and latency.
module tb_pipe_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out;
`ifdef PIPE_ADDER_OVF_EN
  logic        ovf;
`endif

  pipe_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef PIPE_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [16:0] res;
    logic        ov;
    int          adv;
  } exp_t;

  exp_t        sb[$];
  int          tests  = 0;
  int          failed = 0;
  int          adv_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic [15:0] yx;
    yx = s ? ~y : y;
    return {1'b0, x} + {1'b0, yx} + {16'd0, s};
  endfunction

  function automatic logic model_ovf(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic [15:0] yx;
    logic [16:0] r;
    yx = s ? ~y : y;
    r  = model(x, y, s);
    return (x[15] == yx[15]) && (r[15] != x[15]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  initial begin : monitor
    logic        prev_stall;
    logic [16:0] prev_out;
`ifdef PIPE_ADDER_OVF_EN
    logic        prev_ovf;
`endif
    exp_t        e;
    prev_stall = 1'b0;
    prev_out   = '0;
`ifdef PIPE_ADDER_OVF_EN
    prev_ovf   = 1'b0;
`endif
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_out_stable", {15'd0, out}, {15'd0, prev_out});
          check("stall_valid_held", {31'd0, out_valid}, 32'd1);
`ifdef PIPE_ADDER_OVF_EN
          check("stall_ovf_stable", {31'd0, ovf}, {31'd0, prev_ovf});
`endif
        end
        if (out_valid) begin
          if (sb.size() == 0) begin
            check("spurious_result", 32'd1, 32'd0);
          end else if (out_ready) begin
            e = sb.pop_front();
            check("result", {15'd0, out}, {15'd0, e.res});
            check("latency", adv_cnt - e.adv, 32'd4);
`ifdef PIPE_ADDER_OVF_EN
            check("ovf", {31'd0, ovf}, {31'd0, e.ov});
`endif
          end
        end
        if (in_valid && in_ready) begin
          e.res = model(a, b, sub);
          e.ov  = model_ovf(a, b, sub);
          e.adv = adv_cnt;
          sb.push_back(e);
        end
        if (in_ready) adv_cnt++;
        prev_stall = out_valid && !out_ready;
        prev_out   = out;
`ifdef PIPE_ADDER_OVF_EN
        prev_ovf   = ovf;
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Must be called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic sv, output int waits);
    a = av;
    b = bv;
    sub = sv;
    in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", sb.size(), 32'd0);
  endtask

  task automatic release_with(input logic [15:0] av, input logic [15:0] bv, input logic sv);
    rst_n    = 1'b1;
    a        = av;
    b        = bv;
    sub      = sv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin : stimulus
    int w;
    clk = 1'b0;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    sub = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out", {15'd0, out}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef PIPE_ADDER_OVF_EN
    check("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #3;

    // Carry ripples through every segment; accepted on the first edge after release.
    release_with(16'hFFFF, 16'h0001, 1'b0);
    drain();

    // Subtraction with and without borrow.
    send(16'h0005, 16'h0007, 1'b1, w);
    send(16'h0007, 16'h0005, 1'b1, w);
    drain();

    // Signed overflow corners.
    send(16'h7FFF, 16'h0001, 1'b0, w);
    send(16'h8000, 16'h0001, 1'b1, w);
    send(16'h0001, 16'h0001, 1'b0, w);
    drain();

    // Eight back-to-back mixed operations.
    for (int i = 0; i < 8; i++) begin
      send(16'($urandom), 16'($urandom), i[0], w);
      check("b2b_accept_wait", w, 32'd0);
    end
    drain();

    // Backpressure with a full pipe.
    for (int i = 0; i < 4; i++) begin
      send(16'(16'h1111 * (i + 1)), 16'(16'h0F0F + i), i[1], w);
    end
    out_ready = 1'b0;
    a = 16'hABCD;
    b = 16'h1234;
    sub = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'hABCD, 16'h1234, 1'b1, w);
    send(16'h0000, 16'hFFFF, 1'b0, w);
    drain();

    // Reset mid-stream drops in-flight work.
    send(16'h1234, 16'h4321, 1'b0, w);
    send(16'h9999, 16'h1111, 1'b1, w);
    send(16'h0F0F, 16'hF0F0, 1'b0, w);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    #1;
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_out", {15'd0, out}, 32'd0);
    check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #3;
    check("midreset_hold_valid", {31'd0, out_valid}, 32'd0);
    release_with(16'h00FF, 16'h0F01, 1'b1);
    drain();
    repeat (6) @(posedge clk);
    #1;
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits.
REQ-002 SHALL have parameter SEG, default 4: bits summed per pipeline stage; STAGES = WIDTH/SEG.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: operands present.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-007 SHALL have ports a and b, input, WIDTH bits each: unsigned operands.
REQ-008 SHALL have port sub, input, 1 bit: mode, 0 = a+b, 1 = a-b; sampled with the operands.
REQ-009 SHALL have port out_valid, output, 1 bit: result present.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-011 SHALL have port out, output, WIDTH+1 bits: result, with out[WIDTH] = carry-out.

Function
REQ-012 SHALL reject elaboration unless SEG >= 1 and WIDTH is a nonzero multiple of SEG.
REQ-013 SHALL form the sum as a + (sub ? ~b : b) + sub, modulo 2^(WIDTH+1).
- Subtract: out[WIDTH] = 1 means no borrow (a >= b).
REQ-014 SHALL compute segment k (bits k*SEG+SEG-1 .. k*SEG) in stage k, taking the carry registered by stage k-1; stage 0 carry-in = sub.
REQ-015 SHALL delay not-yet-summed operand segments and already-summed result segments through per-stage registers so each result word stays aligned.
REQ-016 SHALL advance the whole pipeline on advance = !out_valid || out_ready; when advance = 0, every stage register holds.
REQ-017 SHALL drive in_ready = advance; an operand is accepted when in_valid && in_ready.
REQ-018 SHALL carry a valid bit per stage; bubbles occupy a stage and are not compressed.
REQ-019 SHALL present each accepted operation on out/out_valid exactly STAGES advancing cycles after acceptance, in acceptance order, with no loss or duplication.
REQ-020 SHALL hold out and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL, when STAGES = 1, behave as a single registered adder with latency 1.
REQ-022 SHALL sustain one result per cycle when in_valid and out_ready are held high.

Reset
REQ-023 SHALL, on rst_n low, clear all stage valid bits, drive out_valid = 0 and out = 0, and drop in-flight operations immediately, without waiting for a clock edge.
REQ-024 SHALL drive in_ready = 1 during and after reset.
REQ-025 SHALL accept a new operand on the first rising edge after rst_n is released.

Configuration
REQ-026 SHALL, when PIPE_ADDER_OVF_EN is defined, add port ovf, output, 1 bit.
- ovf = signed two's-complement overflow of the WIDTH-bit operation, aligned with out.
- ovf = 0 in reset; held under stall like out.
REQ-027 SHALL, when PIPE_ADDER_OVF_EN is undefined, omit port ovf and all overflow logic.

Verification
All scenarios use WIDTH = 16, SEG = 4, so latency = 4.
REQ-028 Reset: rst_n low mid-stream -> out_valid = 0, out = 0, in_ready = 1 at once; the first post-reset result is only the first post-reset operand.
REQ-029 Add carry ripple: a = 0xFFFF, b = 0x0001, sub = 0, out_ready = 1 -> out = 0x10000, out_valid = 1, exactly 4 cycles after acceptance.
REQ-030 Subtract with borrow: a = 0x0005, b = 0x0007, sub = 1 -> out = 0x0FFFE (carry 0).
- Also: a = 0x0007, b = 0x0005 -> out = 0x10002.
REQ-031 Throughput: 8 back-to-back mixed add/sub ops, out_ready = 1 -> 8 consecutive valid results, in order, all matching the reference model.
REQ-032 Backpressure: out_ready = 0 for 5 cycles with the pipe full -> out stable, in_ready = 0, and no result lost or duplicated after out_ready = 1.
REQ-033 With PIPE_ADDER_OVF_EN defined: 0x7FFF + 0x0001 -> ovf = 1; 0x8000 - 0x0001 -> ovf = 1; 0x0001 + 0x0001 -> ovf = 0.
